sm2compl_stream: RTL and testbench

SM2COMPL_STREAM -- requirements
Module: sm2compl_stream

---
 rtl/sm2compl_stream.sv | 109 ++++++++++
 tb/tb_sm2compl_stream.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sm2compl_stream.sv
// sm2compl_stream
//   Converts a stream of sign-magnitude messages to complement code and
//   buffers them in a 2-entry FIFO with a valid/ready handshake on both sides.
//   Every message is tagged with a "last" flag that marks the final message
//   (index DEG-1) of each variable-node group.
//
// Parameters
//   W    message width; bit W-1 is the sign, bits W-2:0 the magnitude
//   DEG  messages per variable-node group (2..64)
//
// Ports
//   i_clk    clock; all state changes on its rising edge
//   i_rst_n  synchronous active-low reset
//   i_valid  upstream offers a message on i_data
//   i_data   sign-magnitude message
//   o_ready  block can accept a message this cycle
//   o_valid  head of the output buffer is valid
//   i_ready  downstream accepts the head this cycle
//   o_data   converted complement-code message at the head
//   o_last   head is the last message of its group
//   o_negz   sticky: a negative-zero input has been accepted since reset
module sm2compl_stream #(
  parameter int W   = 11,
  parameter int DEG = 6
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_ready,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic         o_last,
  output logic         o_negz
);

  localparam int IW = (DEG > 1) ? $clog2(DEG) : 1;

  logic [W-1:0]  buf_data [2];
  logic          buf_last [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic [IW-1:0] grp_idx;
  logic          negz;

  logic          push;
  logic          pop;
  logic          in_sign;
  logic          in_negz;
  logic          grp_end;
  logic [W-1:0]  conv_data;

  // Negative values have their magnitude bits inverted; the sign bit is kept,
  // so negative zero lands on all-ones.
  assign in_sign   = i_data[W-1];
  assign in_negz   = in_sign && (i_data[W-2:0] == '0);
  assign conv_data = {in_sign, i_data[W-2:0] ^ {(W-1){in_sign}}};
  assign grp_end   = (grp_idx == IW'(DEG - 1));

  // Handshake flags come from the registered count only, so o_ready has no
  // combinational dependence on i_ready.
  assign o_ready = (count != 2'd2);
  assign o_valid = (count != 2'd0);
  assign push    = i_valid && o_ready;
  assign pop     = o_valid && i_ready;

  // The storage array is never reset; its contents are only visible once
  // o_valid is set, so outputs are forced to zero while the buffer is empty.
  assign o_data = o_valid ? buf_data[rd_ptr] : '0;
  assign o_last = o_valid && buf_last[rd_ptr];
  assign o_negz = negz;

  always_ff @(posedge i_clk) begin
    if (push) begin
      buf_data[wr_ptr] <= conv_data;
      buf_last[wr_ptr] <= grp_end;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      grp_idx <= '0;
      negz    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr  <= ~wr_ptr;
        grp_idx <= grp_end ? '0 : grp_idx + IW'(1);
        if (in_negz) begin
          negz <= 1'b1;
        end
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sm2compl_stream.sv
// tb_sm2compl_stream
//   Self-checking bench for sm2compl_stream. A driver issues directed and
//   random traffic and pushes the expected conversion of each accepted message
//   into a scoreboard queue; an independent monitor pops and compares whenever
//   the DUT completes an output transfer, and checks the handshake flags and
//   the sticky negative-zero flag against the queue-based model every cycle.
module tb_sm2compl_stream;

  localparam int W   = 11;
  localparam int DEG = 6;

  logic         clk;
  logic         i_rst_n;
  logic         i_valid;
  logic [W-1:0] i_data;
  logic         o_ready;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_data;
  logic         o_last;
  logic         o_negz;

  logic [W:0]   exp_q [$];
  int           grp_m;
  logic         negz_m;
  int           accepted;
  bit           mon_en;
  int           total;
  int           bad;

  sm2compl_stream #(.W(W), .DEG(DEG)) dut (
    .i_clk   (clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_last  (o_last),
    .o_negz  (o_negz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference conversion: a negative message maps to the ones'-complement
  // code of -magnitude, i.e. (2^W - 1) - magnitude.
  function automatic logic [W-1:0] model_conv(input logic [W-1:0] d);
    int mag;
    mag = int'(d[W-2:0]);
    if (d[W-1]) return W'((1 << W) - 1 - mag);
    return d;
  endfunction

  function automatic logic [W-1:0] rand_data();
    logic [W-1:0] nz;
    nz = '0;
    nz[W-1] = 1'b1;
    if ($urandom_range(0, 15) == 0) return nz;
    return W'($urandom);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs and, just before the rising edge, updates the
  // reference model with whatever the DUT is about to accept.
  task automatic apply_stimulus(input logic v, input logic [W-1:0] d,
                                input logic r, input logic rn);
    logic [W-1:0] nz;
    nz = '0;
    nz[W-1] = 1'b1;
    @(negedge clk);
    i_valid = v;
    i_data  = d;
    i_ready = r;
    i_rst_n = rn;
    #3;
    if (!rn) begin
      exp_q.delete();
      grp_m  = 0;
      negz_m = 1'b0;
    end else if (i_valid && o_ready) begin
      exp_q.push_back({(grp_m == DEG - 1), model_conv(d)});
      if (d == nz) negz_m = 1'b1;
      grp_m = (grp_m + 1) % DEG;
      accepted++;
    end
  endtask

  task automatic do_reset();
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    apply_stimulus(1'b0, '0, 1'b0, 1'b1);
  endtask

  // Monitor: flags and output transfers, sampled well before the rising edge.
  initial begin
    logic [W:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        check_output("occ_valid", 32'(o_valid), 32'(exp_q.size() != 0));
        check_output("occ_ready", 32'(o_ready), 32'(exp_q.size() < 2));
        check_output("negz_flag", 32'(o_negz), 32'(negz_m));
        if (o_valid && i_ready) begin
          if (exp_q.size() == 0) begin
            check_output("unexpected_output", 32'(o_data), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check_output("out_data", 32'(o_data), 32'(e[W-1:0]));
            check_output("out_last", 32'(o_last), 32'(e[W]));
          end
        end
      end
    end
  end

  initial begin
    int cyc;
    total    = 0;
    bad      = 0;
    grp_m    = 0;
    negz_m   = 1'b0;
    accepted = 0;
    mon_en   = 1'b0;
    i_rst_n  = 1'b0;
    i_valid  = 1'b0;
    i_data   = '0;
    i_ready  = 1'b0;

    // Reset state, both during and after the reset edge.
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    check_output("rst_hold_valid", 32'(o_valid), 32'd0);
    check_output("rst_hold_ready", 32'(o_ready), 32'd1);
    apply_stimulus(1'b0, '0, 1'b0, 1'b1);
    check_output("rst_valid", 32'(o_valid), 32'd0);
    check_output("rst_ready", 32'(o_ready), 32'd1);
    check_output("rst_last",  32'(o_last),  32'd0);
    check_output("rst_data",  32'(o_data),  32'd0);
    check_output("rst_negz",  32'(o_negz),  32'd0);
    mon_en = 1'b1;

    // Single negative message, one-cycle latency.
    apply_stimulus(1'b1, 11'h405, 1'b1, 1'b1);
    apply_stimulus(1'b0, '0, 1'b1, 1'b1);
    check_output("lat_valid", 32'(o_valid), 32'd1);
    check_output("lat_data",  32'(o_data),  32'h7FA);
    check_output("lat_last",  32'(o_last),  32'd0);

    // Negative zero then a positive value.
    apply_stimulus(1'b1, 11'h400, 1'b1, 1'b1);
    apply_stimulus(1'b1, 11'h123, 1'b1, 1'b1);
    check_output("negzero_data", 32'(o_data), 32'h7FF);
    check_output("negzero_flag", 32'(o_negz), 32'd1);
    apply_stimulus(1'b0, '0, 1'b1, 1'b1);
    check_output("positive_data", 32'(o_data), 32'h123);
    check_output("negz_sticky",   32'(o_negz), 32'd1);

    // 13-message stream at full rate: last on outputs 6 and 12 only.
    do_reset();
    for (int i = 0; i <= 13; i++) begin
      apply_stimulus(i < 13, rand_data(), 1'b1, 1'b1);
      if (i >= 1) begin
        check_output("stream_valid", 32'(o_valid), 32'd1);
        check_output("stream_ready", 32'(o_ready), 32'd1);
        check_output("stream_last",  32'(o_last),  32'(i % 6 == 0));
      end
    end

    // Back-pressure: three offered, two accepted, head held stable.
    do_reset();
    apply_stimulus(1'b1, 11'h0AA, 1'b0, 1'b1);
    apply_stimulus(1'b1, 11'h455, 1'b0, 1'b1);
    apply_stimulus(1'b1, 11'h013, 1'b0, 1'b1);
    check_output("full_ready",  32'(o_ready), 32'd0);
    check_output("full_head",   32'(o_data),  32'h0AA);
    apply_stimulus(1'b0, '0, 1'b0, 1'b1);
    check_output("stall_head",  32'(o_data),  32'h0AA);
    check_output("stall_valid", 32'(o_valid), 32'd1);
    apply_stimulus(1'b0, '0, 1'b1, 1'b1);
    check_output("pop_ready_before", 32'(o_ready), 32'd0);
    apply_stimulus(1'b0, '0, 1'b1, 1'b1);
    check_output("pop_ready_after",  32'(o_ready), 32'd1);
    check_output("second_data",      32'(o_data),  32'h7AA);
    apply_stimulus(1'b0, '0, 1'b1, 1'b1);
    check_output("drained_valid", 32'(o_valid), 32'd0);

    // Reset with a full buffer at group index 3.
    do_reset();
    apply_stimulus(1'b1, 11'h400, 1'b1, 1'b1);
    apply_stimulus(1'b1, 11'h011, 1'b1, 1'b1);
    apply_stimulus(1'b1, 11'h022, 1'b0, 1'b1);
    apply_stimulus(1'b0, '0, 1'b0, 1'b1);
    check_output("pre_rst_ready", 32'(o_ready), 32'd0);
    check_output("pre_rst_negz",  32'(o_negz),  32'd1);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    apply_stimulus(1'b0, '0, 1'b0, 1'b1);
    check_output("mid_rst_valid", 32'(o_valid), 32'd0);
    check_output("mid_rst_ready", 32'(o_ready), 32'd1);
    check_output("mid_rst_negz",  32'(o_negz),  32'd0);
    check_output("mid_rst_data",  32'(o_data),  32'd0);
    for (int i = 0; i <= 6; i++) begin
      apply_stimulus(i < 6, rand_data(), 1'b1, 1'b1);
      if (i >= 1) begin
        check_output("post_rst_last", 32'(o_last), 32'(i == 6));
      end
    end

    // Random traffic against the scoreboard.
    do_reset();
    accepted = 0;
    cyc = 0;
    while (accepted < 10000 && cyc < 60000) begin
      apply_stimulus($urandom_range(0, 3) != 0, rand_data(),
                     $urandom_range(0, 3) != 0, 1'b1);
      cyc++;
    end
    check_output("random_accepted", 32'(accepted), 32'd10000);

    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      apply_stimulus(1'b0, '0, 1'b1, 1'b1);
      cyc++;
    end
    apply_stimulus(1'b0, '0, 1'b1, 1'b1);
    check_output("drain_queue", 32'(exp_q.size()), 32'd0);
    check_output("drain_valid", 32'(o_valid), 32'd0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
